poly_eval_pipe: RTL and testbench

//  Pipelined, parametrised polynomial evaluator: y = sum(c[i]*x^i, i=0..DEGREE), computed by Horner's rule.

---
 rtl/poly_pkg.sv | 23 ++
 rtl/poly_stage.sv | 61 ++++++
 rtl/poly_eval_pipe.sv | 127 ++++++++++++
 tb/tb_poly_eval_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// poly_pkg: shared defaults and helpers for the Horner polynomial pipeline
// Rev 1.0
// ----------------------------------------------------------------------------
package poly_pkg;

  localparam int DEF_W      = 8;
  localparam int DEF_OW     = 32;
  localparam int DEF_DEGREE = 3;

  // Coefficient index width; never narrower than one bit.
  function automatic int idx_width(input int degree);
    return (degree < 1) ? 1 : $clog2(degree + 1);
  endfunction

  // Reset value of c[i]: 0 for the constant term, 1 for every power of x.
  function automatic logic default_coef_bit(input int i);
    return (i != 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// poly_stage: one Horner multiply-add stage, acc = prev_acc * x + coef
// Rev 1.0
// ----------------------------------------------------------------------------
module poly_stage
  import poly_pkg::*;
#(
  parameter int OW = DEF_OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prev_valid_i,
  input  logic [OW-1:0] prev_x_i,
  input  logic [OW-1:0] prev_acc_i,
  input  logic [OW-1:0] coef_i,
  input  logic          next_ready_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [OW-1:0] x_o,
  output logic [OW-1:0] acc_o
);

  typedef struct packed {
    logic          valid;
    logic [OW-1:0] x;
    logic [OW-1:0] acc;
  } stage_t;

  stage_t        stage_q;
  stage_t        stage_d;
  logic [OW-1:0] w_mac;

  assign w_mac   = prev_acc_i * prev_x_i + coef_i;
  assign ready_o = ~stage_q.valid | next_ready_i;

  always_comb begin
    stage_d = stage_q;
    if (ready_o) begin
      stage_d.valid = prev_valid_i;
      if (prev_valid_i) begin
        stage_d.x   = prev_x_i;
        stage_d.acc = w_mac;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_o = stage_q.valid;
  assign x_o     = stage_q.x;
  assign acc_o   = stage_q.acc;

endmodule
`default_nettype wire

// File: rtl/poly_eval_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// poly_eval_pipe: pipelined Horner evaluator with valid/ready flow control
// Rev 1.0
// ----------------------------------------------------------------------------
module poly_eval_pipe
  import poly_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int OW     = DEF_OW,
  parameter int DEGREE = DEF_DEGREE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 x_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OW-1:0]                y_out,
  input  logic                         coef_we,
  input  logic [idx_width(DEGREE)-1:0] coef_idx,
  input  logic [OW-1:0]                coef_wdata,
  output logic                         busy,
  output logic                         coef_err
);

  localparam int IW = idx_width(DEGREE);

  typedef struct packed {
    logic          valid;
    logic [OW-1:0] x;
    logic [OW-1:0] acc;
  } stage_t;

  logic [OW-1:0]   coef_q [DEGREE+1];
  logic            coef_err_q;
  stage_t          stage0_q;
  stage_t          stage0_d;

  // Index k is stage k; w_ready[DEGREE+1] is the sink's acceptance.
  logic [DEGREE:0]   w_valid;
  logic [OW-1:0]     w_x   [DEGREE+1];
  logic [OW-1:0]     w_acc [DEGREE+1];
  logic [DEGREE+1:0] w_ready;

  logic w_in_fire;
  logic w_busy;
  logic w_idx_ok;
  logic w_coef_accept;

  assign w_ready[DEGREE+1] = out_ready;
  assign w_ready[0]        = ~stage0_q.valid | w_ready[1];
  assign w_in_fire         = in_valid & w_ready[0];

  assign w_valid[0] = stage0_q.valid;
  assign w_x[0]     = stage0_q.x;
  assign w_acc[0]   = stage0_q.acc;

  always_comb begin
    stage0_d = stage0_q;
    if (w_ready[0]) begin
      stage0_d.valid = in_valid;
      if (in_valid) begin
        stage0_d.x   = OW'(x_in);
        stage0_d.acc = coef_q[DEGREE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage0_q <= '0;
    end else begin
      stage0_q <= stage0_d;
    end
  end

  for (genvar k = 1; k <= DEGREE; k++) begin : g_stage
    poly_stage #(
      .OW (OW)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .prev_valid_i (w_valid[k-1]),
      .prev_x_i     (w_x[k-1]),
      .prev_acc_i   (w_acc[k-1]),
      .coef_i       (coef_q[DEGREE-k]),
      .next_ready_i (w_ready[k+1]),
      .ready_o      (w_ready[k]),
      .valid_o      (w_valid[k]),
      .x_o          (w_x[k]),
      .acc_o        (w_acc[k])
    );
  end

  // Writes only land on an empty pipe so every in-flight result sees one coefficient set.
  assign w_busy        = |w_valid;
  assign w_idx_ok      = (coef_idx <= IW'(DEGREE));
  assign w_coef_accept = coef_we & w_idx_ok & ~w_busy & ~w_in_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DEGREE; i++) begin
        coef_q[i] <= {{(OW-1){1'b0}}, default_coef_bit(i)};
      end
      coef_err_q <= 1'b0;
    end else begin
      coef_err_q <= coef_we & ~w_coef_accept;
      if (w_coef_accept) begin
        for (int i = 0; i <= DEGREE; i++) begin
          if (coef_idx == IW'(i)) begin
            coef_q[i] <= coef_wdata;
          end
        end
      end
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[DEGREE];
  assign y_out     = w_acc[DEGREE];
  assign busy      = w_busy;
  assign coef_err  = coef_err_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_eval_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_poly_eval_pipe: directed and randomized checks of poly_eval_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_poly_eval_pipe;

  localparam int DEGREE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y_out;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_idx = '0;
  logic [31:0] coef_wdata = '0;
  logic        busy;
  logic        coef_err;

  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] y16;
  logic        busy16;
  logic        coef_err16;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [31:0] m_coef [DEGREE+1];
  logic [31:0] q [$];
  logic        err_exp;
  logic        stall_prev;
  logic [31:0] stall_y;

  always #5 clk = ~clk;

  poly_eval_pipe #(.W(8), .OW(32), .DEGREE(DEGREE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_wdata(coef_wdata),
    .busy(busy), .coef_err(coef_err)
  );

  poly_eval_pipe #(.W(8), .OW(16), .DEGREE(DEGREE)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .x_in(x_in),
    .out_valid(out_valid16), .out_ready(out_ready), .y_out(y16),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_wdata(coef_wdata[15:0]),
    .busy(busy16), .coef_err(coef_err16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Sum of c[i]*x^i with 32-bit wrap, evaluated term by term.
  function automatic logic [31:0] ref_poly(input logic [31:0] x);
    logic [31:0] sum;
    logic [31:0] xp;
    sum = '0;
    xp  = 32'd1;
    for (int i = 0; i <= DEGREE; i++) begin
      sum = sum + m_coef[i] * xp;
      xp  = xp * x;
    end
    return sum;
  endfunction

  // Reference model: in-order queue of expected results plus coefficient shadow.
  always @(negedge clk) begin
    int  n_inflight;
    bit  accept;
    if (rst) begin
      q.delete();
      for (int i = 0; i <= DEGREE; i++) m_coef[i] = (i == 0) ? 32'd0 : 32'd1;
      err_exp    = 1'b0;
      stall_prev = 1'b0;
    end else if (mon_en) begin
      n_inflight = q.size();
      check("busy", busy, n_inflight != 0);
      check("in_ready", in_ready, (n_inflight < DEGREE + 1) || out_ready);
      check("coef_err", coef_err, err_exp);
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_y", y_out, stall_y);
      end
      if (q.size() == 0) begin
        check("no_spurious_out", out_valid, 0);
      end else if (out_valid && out_ready) begin
        check("y_out", y_out, q.pop_front());
      end
      stall_prev = out_valid & ~out_ready;
      stall_y    = y_out;
      accept  = coef_we && (n_inflight == 0) && !(in_valid && in_ready) && (int'(coef_idx) <= DEGREE);
      err_exp = coef_we && !accept;
      if (in_valid && in_ready) q.push_back(ref_poly({24'd0, x_in}));
      if (accept) m_coef[coef_idx] = coef_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic run_one(input logic [7:0] x, input logic [31:0] exp, input string tag);
    step();
    in_valid = 1'b1; x_in = x; out_ready = 1'b1;
    sample();
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      sample();
      if (c < 4) begin
        check({tag, "_early"}, out_valid, 0);
        step();
      end else begin
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_y"}, y_out, exp);
      end
    end
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!(out_valid === 1'b1 && out_ready) && n < 20) begin
      step();
      sample();
      n++;
    end
    check({tag, "_seen"}, out_valid, 1);
    check({tag, "_y"}, y_out, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got [$];
    logic [31:0] exp_bp [5];
    int nx;
    int n_in;
    int cyc;
    exp_bp = '{32'd3, 32'd14, 32'd39, 32'd84, 32'd155};

    repeat (2) step();
    rst = 1'b0;
    mon_en = 1'b1;
    sample();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_coef_err", coef_err, 0);
    check("rst_y_out", y_out, 0);

    // Default coefficients, exact latency, 16-bit wrap on the second instance.
    run_one(8'd2, 32'd14, "x2");
    check("w16_x2_y", y16, 14);
    run_one(8'd255, 32'd16646655, "x255");
    check("w16_valid", out_valid16, 1);
    check("w16_x255_y", y16, 511);
    check("w16_busy", busy16, 1);
    check("w16_coef_err", coef_err16, 0);
    check("w16_in_ready", in_ready16, 1);

    // Idle write of c[0]=5.
    step();
    coef_we = 1'b1; coef_idx = 2'd0; coef_wdata = 32'd5;
    sample();
    step();
    coef_we = 1'b0;
    sample();
    check("idle_wr_err", coef_err, 0);
    run_one(8'd2, 32'd19, "c0_5");

    // Write while busy is rejected.
    step();
    in_valid = 1'b1; x_in = 8'd2;
    sample();
    step();
    in_valid = 1'b0; coef_we = 1'b1; coef_idx = 2'd0; coef_wdata = 32'd100;
    sample();
    check("busy_wr_busy", busy, 1);
    step();
    coef_we = 1'b0;
    sample();
    check("busy_wr_err", coef_err, 1);
    wait_out("busy_wr", 32'd19);

    // Write in the same cycle as an input fire is rejected.
    step();
    in_valid = 1'b1; x_in = 8'd2; coef_we = 1'b1; coef_idx = 2'd1; coef_wdata = 32'd7;
    sample();
    step();
    in_valid = 1'b0; coef_we = 1'b0;
    sample();
    check("fire_wr_err", coef_err, 1);
    wait_out("fire_wr", 32'd19);

    // Reset with three results in flight.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      in_valid = 1'b1; x_in = 8'(i);
      sample();
    end
    step();
    in_valid = 1'b0;
    repeat (3) begin sample(); step(); end
    sample();
    check("pre_rst_out_valid", out_valid, 1);
    step();
    rst = 1'b1;
    sample();
    step();
    rst = 1'b0;
    sample();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      sample();
      check("no_late_out", out_valid, 0);
    end
    run_one(8'd2, 32'd14, "post_rst");

    // Backpressure: fill with out_ready low, then release.
    got.delete();
    nx = 1;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      step();
      in_valid = (nx <= 5); x_in = 8'(nx); out_ready = (c >= 10);
      sample();
      if (c == 9) begin
        check("bp_accepted", 64'(nx - 1), 4);
        check("bp_in_ready", in_ready, 0);
      end
      if (in_valid && in_ready) nx++;
      if (out_valid && out_ready) got.push_back(y_out);
    end
    step();
    in_valid = 1'b0;
    check("bp_count", 64'(got.size()), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check($sformatf("bp_out%0d", i), got[i], exp_bp[i]);
    end

    // Randomized traffic with idle windows so some coefficient writes land.
    n_in = 0;
    cyc  = 0;
    while ((n_in < 1000 || q.size() != 0) && cyc < 30000) begin
      step();
      in_valid   = (n_in < 1000) && ((cyc % 100) > 12) && ($urandom_range(0, 9) < 7);
      x_in       = 8'($urandom_range(0, 255));
      out_ready  = ($urandom_range(0, 9) < 7);
      coef_we    = ($urandom_range(0, 19) == 0);
      coef_idx   = 2'($urandom_range(0, 3));
      coef_wdata = $urandom;
      sample();
      if (in_valid && in_ready) n_in++;
      cyc++;
    end
    step();
    in_valid = 1'b0; coef_we = 1'b0;
    sample();
    check("rand_count", 64'(n_in), 1000);
    check("rand_drained", 64'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
